// File: rtl/lock_sequencer.sv
// -----------------------------------------------------------------------------
// lock_sequencer
//   Passcode entry controller for the keypad lock. Collects keypad digits into
//   an entry buffer, checks them against the stored code on enter, holds the
//   lock open for a fixed time, counts consecutive failures and enforces a
//   timed lockout once too many failures occur.
//
// Optional feature (compile-time macro): LOCK_SEQUENCER_CODE_CHANGE_EN
//   When defined, a set_code input exists. Asserting it while the lock is open
//   enters a code-change mode in which a new code can be keyed in.
//   When undefined, the code is the constant DEFAULT_CODE.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   digit_in     in   keypad digit, qualified by digit_valid
//   digit_valid  in   one-cycle digit strobe
//   enter        in   one-cycle check request
//   clear        in   one-cycle discard of partial entry
//   lock_now     in   forces relock while open
//   set_code     in   enter code-change mode (macro builds only)
//   unlocked     out  lock open (registered)
//   locked_out   out  lockout active (registered)
//   fail_pulse   out  one-cycle pulse per failed check (registered)
//   digit_count  out  digits currently buffered (registered)
// -----------------------------------------------------------------------------
module lock_sequencer #(
    parameter int                        DIGITS       = 4,
    parameter int                        DIGIT_W      = 4,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1A2B,
    parameter int                        MAX_FAIL     = 3,
    parameter int                        OPEN_CYC     = 8,
    parameter int                        LOCKOUT_CYC  = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [DIGIT_W-1:0]          digit_in,
    input  logic                        digit_valid,
    input  logic                        enter,
    input  logic                        clear,
    input  logic                        lock_now,
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
    input  logic                        set_code,
`endif
    output logic                        unlocked,
    output logic                        locked_out,
    output logic                        fail_pulse,
    output logic [$clog2(DIGITS+1)-1:0] digit_count
);

    localparam int CODE_W  = DIGITS * DIGIT_W;
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMR_OPEN = TMR_W'(OPEN_CYC);
    localparam logic [TMR_W-1:0] TMR_LOCK = TMR_W'(LOCKOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_SETCODE = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;
`endif

    // Registers
    state_t              r_state;
    logic [CODE_W-1:0]   r_buf;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_fail_cnt;
    logic [TMR_W-1:0]    r_timer;
    logic                r_unlocked;
    logic                r_locked_out;
    logic                r_fail_pulse;
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
    logic [CODE_W-1:0]   r_code;
    logic [CODE_W-1:0]   w_code_nxt;
`endif

    // Combinational next-state values
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   w_buf_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [7:0]          w_fail_nxt;
    logic [7:0]          w_fail_inc;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic                w_fail_pulse_nxt;
    logic [CODE_W-1:0]   w_acc_buf;
    logic [CNT_W-1:0]    w_acc_cnt;
    logic [CODE_W-1:0]   w_code;
    logic                w_pass;

`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
    assign w_code = r_code;
`else
    assign w_code = DEFAULT_CODE;
`endif

    assign w_pass = (r_cnt == CNT_FULL) && (r_buf == w_code);

    // Saturating increment; failures only ever count consecutively.
    assign w_fail_inc = (r_fail_cnt == 8'hFF) ? 8'hFF : (r_fail_cnt + 8'd1);

    // Buffer/count as they would be after accepting this cycle's digit.
    // A full buffer ignores further digits so the first DIGITS keys are kept.
    always_comb begin
        w_acc_buf = r_buf;
        w_acc_cnt = r_cnt;
        if (digit_valid && (r_cnt < CNT_FULL)) begin
            w_acc_buf = (r_buf << DIGIT_W) | CODE_W'(digit_in);
            w_acc_cnt = r_cnt + CNT_ONE;
        end else begin
            w_acc_buf = r_buf;
            w_acc_cnt = r_cnt;
        end
    end

    // Next-state and datapath decode for the sequencer FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_buf_nxt        = r_buf;
        w_cnt_nxt        = r_cnt;
        w_fail_nxt       = r_fail_cnt;
        w_timer_nxt      = r_timer;
        w_fail_pulse_nxt = 1'b0;
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
        w_code_nxt       = r_code;
`endif
        case (r_state)
            S_IDLE, S_ENTRY: begin
                if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (enter) begin
                    // A digit arriving with enter is included in the check.
                    w_buf_nxt   = w_acc_buf;
                    w_cnt_nxt   = w_acc_cnt;
                    w_state_nxt = S_CHECK;
                end else if (digit_valid) begin
                    w_buf_nxt   = w_acc_buf;
                    w_cnt_nxt   = w_acc_cnt;
                    w_state_nxt = S_ENTRY;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_CHECK: begin
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
                if (w_pass) begin
                    w_state_nxt = S_OPEN;
                    w_timer_nxt = TMR_OPEN;
                    w_fail_nxt  = 8'd0;
                end else begin
                    w_fail_pulse_nxt = 1'b1;
                    if (int'(w_fail_inc) == MAX_FAIL) begin
                        w_state_nxt = S_LOCKOUT;
                        w_timer_nxt = TMR_LOCK;
                        w_fail_nxt  = 8'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_fail_nxt  = w_fail_inc;
                    end
                end
            end
            S_OPEN: begin
                // Timer holds the number of open cycles still to run,
                // including the current one; leave when it is the last.
                if (lock_now) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
                end else if (set_code) begin
                    w_state_nxt = S_SETCODE;
                    w_timer_nxt = '0;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
`endif
                end else if (r_timer <= TMR_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
            S_LOCKOUT: begin
                if (r_timer <= TMR_ONE) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - TMR_ONE;
                end
            end
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
            S_SETCODE: begin
                if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (enter) begin
                    // Only a complete code replaces the stored one.
                    if (w_acc_cnt == CNT_FULL) begin
                        w_code_nxt = w_acc_buf;
                    end else begin
                        w_code_nxt = r_code;
                    end
                    w_state_nxt = S_IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (digit_valid) begin
                    w_buf_nxt = w_acc_buf;
                    w_cnt_nxt = w_acc_cnt;
                end else begin
                    w_state_nxt = S_SETCODE;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_buf_nxt   = '0;
                w_cnt_nxt   = '0;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_fail_cnt   <= 8'd0;
            r_timer      <= '0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_fail_pulse <= 1'b0;
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
            r_code       <= DEFAULT_CODE;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_timer      <= w_timer_nxt;
            // Status flags follow the state being entered so they change on
            // the same edge as the state itself.
            r_unlocked   <= (w_state_nxt == S_OPEN);
            r_locked_out <= (w_state_nxt == S_LOCKOUT);
            r_fail_pulse <= w_fail_pulse_nxt;
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
            r_code       <= w_code_nxt;
`endif
        end
    end

    assign unlocked    = r_unlocked;
    assign locked_out  = r_locked_out;
    assign fail_pulse  = r_fail_pulse;
    assign digit_count = r_cnt;

endmodule

// File: tb/tb_lock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lock_sequencer
//   Scoreboard bench for lock_sequencer. The driver applies one input vector
//   per clock and, after each rising edge, advances a behavioural model of the
//   lock (entered digits kept as a list, open/lockout tracked as an absolute
//   end cycle) and queues the outputs expected after that edge. A monitor on
//   the falling edge pops each expectation and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_lock_sequencer;

    localparam int          DIGITS       = 4;
    localparam int          DIGIT_W      = 4;
    localparam int          MAX_FAIL     = 3;
    localparam int          OPEN_CYC     = 8;
    localparam int          LOCKOUT_CYC  = 16;
    localparam logic [15:0] DEFAULT_CODE = 16'h1A2B;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic [3:0] digit_in    = 4'd0;
    logic       digit_valid = 1'b0;
    logic       enter       = 1'b0;
    logic       clear       = 1'b0;
    logic       lock_now    = 1'b0;
    logic       set_code    = 1'b0;
    logic       unlocked;
    logic       locked_out;
    logic       fail_pulse;
    logic [2:0] digit_count;

    always #5 clk = ~clk;

    lock_sequencer #(
        .DIGITS       (DIGITS),
        .DIGIT_W      (DIGIT_W),
        .DEFAULT_CODE (DEFAULT_CODE),
        .MAX_FAIL     (MAX_FAIL),
        .OPEN_CYC     (OPEN_CYC),
        .LOCKOUT_CYC  (LOCKOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .enter       (enter),
        .clear       (clear),
        .lock_now    (lock_now),
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
        .set_code    (set_code),
`endif
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .fail_pulse  (fail_pulse),
        .digit_count (digit_count)
    );

    typedef struct packed {
        logic       unl;
        logic       lko;
        logic       fp;
        logic [2:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------- behavioural model ----------------
    typedef enum int {M_READY, M_CHECKING, M_OPEN, M_LOCK, M_SET} mmode_t;
    mmode_t      m_mode;
    int          m_digits[$];
    int          m_fails;
    int          m_until;
    int          m_edge = 0;
    logic [15:0] m_code;

    task automatic model_reset();
        m_mode = M_READY;
        m_digits.delete();
        m_fails = 0;
        m_until = 0;
        m_code  = DEFAULT_CODE;
    endtask

    function automatic logic [15:0] digits_value();
        logic [15:0] v = 16'h0000;
        foreach (m_digits[i]) v = (v << 4) | 16'(m_digits[i]);
        return v;
    endfunction

    task automatic take_digit();
        if (digit_valid && m_digits.size() < DIGITS) m_digits.push_back(int'(digit_in));
    endtask

    // One rising edge of the lock, using the inputs currently applied.
    task automatic model_edge();
        exp_t e;
        logic fp = 1'b0;
        m_edge++;
        if (!reset_n) begin
            model_reset();
        end else begin
            case (m_mode)
                M_READY: begin
                    if (clear) m_digits.delete();
                    else begin
                        take_digit();
                        if (enter) m_mode = M_CHECKING;
                    end
                end
                M_CHECKING: begin
                    if (m_digits.size() == DIGITS && digits_value() == m_code) begin
                        m_mode  = M_OPEN;
                        m_until = m_edge + OPEN_CYC;
                        m_fails = 0;
                    end else begin
                        fp = 1'b1;
                        m_fails++;
                        if (m_fails == MAX_FAIL) begin
                            m_mode  = M_LOCK;
                            m_until = m_edge + LOCKOUT_CYC;
                            m_fails = 0;
                        end else m_mode = M_READY;
                    end
                    m_digits.delete();
                end
                M_OPEN: begin
                    if (lock_now) m_mode = M_READY;
`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
                    else if (set_code) m_mode = M_SET;
`endif
                    else if (m_edge >= m_until) m_mode = M_READY;
                end
                M_LOCK: begin
                    if (m_edge >= m_until) m_mode = M_READY;
                end
                M_SET: begin
                    if (clear) begin
                        m_digits.delete();
                        m_mode = M_READY;
                    end else begin
                        take_digit();
                        if (enter) begin
                            if (m_digits.size() == DIGITS) m_code = digits_value();
                            m_digits.delete();
                            m_mode = M_READY;
                        end
                    end
                end
                default: m_mode = M_READY;
            endcase
        end
        e.unl = (m_mode == M_OPEN);
        e.lko = (m_mode == M_LOCK);
        e.fp  = fp;
        e.cnt = 3'(m_digits.size());
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if ({unlocked, locked_out, fail_pulse, digit_count} !== mon_e) begin
                n_err++;
                $display("FAIL outputs @%0t: got unl=%b lko=%b fp=%b cnt=%0d, expected unl=%b lko=%b fp=%b cnt=%0d",
                         $time, unlocked, locked_out, fail_pulse, digit_count,
                         mon_e.unl, mon_e.lko, mon_e.fp, mon_e.cnt);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input logic dv, input logic [3:0] d, input logic en,
                        input logic cl, input logic ln, input logic sc);
        digit_valid = dv;
        digit_in    = d;
        enter       = en;
        clear       = cl;
        lock_now    = ln;
        set_code    = sc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [3:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_enter();
        step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic try_code(input logic [15:0] c);
        key(c[15:12]); key(c[11:8]); key(c[7:4]); key(c[3:0]);
        press_enter();
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if (unlocked !== 1'b0 || locked_out !== 1'b0 || fail_pulse !== 1'b0 || digit_count !== 3'd0) begin
            n_err++;
            $display("FAIL %s: got unl=%b lko=%b fp=%b cnt=%0d, expected all zero",
                     tag, unlocked, locked_out, fail_pulse, digit_count);
        end
    endtask

    logic       r_dv, r_en, r_cl, r_ln, r_sc;
    logic [3:0] r_d;
    int         r_sz;

    initial begin
        model_reset();
        #1 check_zero("reset_state");
        idle(2);
        reset_n = 1'b1;

        // Correct code opens for OPEN_CYC cycles.
        try_code(16'h1A2B);
        idle(11);

        // Three wrong tries -> lockout; input during lockout ignored.
        try_code(16'h1A2C); idle(1);
        try_code(16'h1A2C); idle(1);
        try_code(16'h1A2C);
        idle(1);
        try_code(16'h1A2B);
        idle(14);

        // Pass in between clears the failure count.
        try_code(16'h1A2C); idle(1);
        try_code(16'h1A2C); idle(1);
        try_code(16'h1A2B); idle(10);
        try_code(16'h1A2C); idle(1);
        try_code(16'h1A2C); idle(2);

        // Clear then correct code; last digit together with enter.
        key(4'h1); key(4'hA);
        step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        try_code(16'h1A2B); idle(10);
        key(4'h1); key(4'hA); key(4'h2);
        step(1'b1, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Six digits: only the first four are kept.
        key(4'h1); key(4'hA); key(4'h2); key(4'hB); key(4'h3); key(4'h4);
        press_enter(); idle(10);

        // Clear and enter in the same cycle: clear wins, no failure.
        key(4'h7);
        step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        press_enter(); idle(2);

        // lock_now at the third open cycle.
        try_code(16'h1A2B); idle(3);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Asynchronous reset mid-entry.
        key(4'h1); key(4'hA);
        #2 reset_n = 1'b0;
        #1 check_zero("async_reset");
        idle(1);
        reset_n = 1'b1;
        idle(1);

`ifdef LOCK_SEQUENCER_CODE_CHANGE_EN
        // Change code to 5555, old code fails, new opens; short entry aborts.
        try_code(16'h1A2B); idle(2);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        try_code(16'h5555); idle(1);
        try_code(16'h1A2B); idle(1);
        try_code(16'h5555); idle(2);
        step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        key(4'h5); key(4'h5); press_enter(); idle(1);
        try_code(16'h5555); idle(10);
        // Reset restores the default code.
        reset_n = 1'b0; idle(1); reset_n = 1'b1;
        try_code(16'h1A2B); idle(10);
`endif

        // Randomized traffic, biased toward the currently stored code.
        for (int k = 0; k < 600; k++) begin
            r_dv = ($urandom_range(0, 9) < 4);
            r_sz = m_digits.size();
            if ($urandom_range(0, 9) < 7 && r_sz < DIGITS) r_d = m_code[(15 - 4 * r_sz) -: 4];
            else r_d = 4'($urandom_range(0, 15));
            r_en = ($urandom_range(0, 99) < 10);
            r_cl = ($urandom_range(0, 99) < 3);
            r_ln = ($urandom_range(0, 99) < 4);
            r_sc = ($urandom_range(0, 99) < 4);
            step(r_dv, r_d, r_en, r_cl, r_ln, r_sc);
        end
        idle(2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Controller that sequences multi-digit passcode entry for the keypad lock datapath. It collects digits into an entry buffer and compares them against the stored code on `enter`. It drives the open/closed status with an auto-relock timer, counts failed attempts and enforces a timed lockout. It sits between the keypad decoder (one digit per `digit_valid` strobe) and the door actuator / status LEDs.

## Interface
- `DIGITS`, 4: digits per code.
- `DIGIT_W`, 4: bits per digit.
- `DEFAULT_CODE`, 16'h1A2B: code after reset. Width is DIGITS*DIGIT_W; the first digit entered sits in the MSBs.
- `MAX_FAIL`, 3: consecutive failures that trigger lockout (≥1).
- `OPEN_CYC`, 8: cycles `unlocked` stays high (≥1).
- `LOCKOUT_CYC`, 16: cycles `locked_out` stays high (≥1).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `digit_in`  in  DIGIT_W  keypad digit.
- `digit_valid`  in  1  one-cycle strobe qualifying `digit_in`.
- `enter`  in  1  one-cycle strobe requesting a check.
- `clear`  in  1  one-cycle strobe that discards partial entry.
- `lock_now`  in  1  forces relock while open.
- `set_code`  in  1  enters code-change mode; present only with the macro.
- `unlocked`  out  1  lock open.
- `locked_out`  out  1  lockout active.
- `fail_pulse`  out  1  one-cycle pulse per failed check.
- `digit_count`  out  $clog2(DIGITS+1)  digits currently buffered.

## Operation
- States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT, plus SETCODE with the macro.
- Reset values: state IDLE, buffer 0, `digit_count` 0, fail counter 0, timer 0, all outputs 0, stored code `DEFAULT_CODE`.
- IDLE/ENTRY, on `digit_valid`:
  - Shift the buffer left by DIGIT_W and place `digit_in` in the LSBs.
  - `digit_count`++; state becomes ENTRY.
  - At `digit_count`==DIGITS, further digits are ignored: no shift, count holds.
- IDLE/ENTRY, on `enter`: go to CHECK. `enter` is valid with any count, including 0.
- `digit_valid` and `enter` in the same cycle: the digit is accepted first, then the check includes it.
- `clear` (IDLE/ENTRY): buffer and count go to 0, state IDLE, no failure recorded. `clear` has priority over `digit_valid` and `enter` in the same cycle.
- CHECK (exactly one cycle). Pass condition: `digit_count`==DIGITS and buffer == stored code.
  - Pass: go to OPEN, load timer with OPEN_CYC, clear the fail counter.
  - Fail: assert `fail_pulse`, fail counter++.
    - New count == MAX_FAIL: go to LOCKOUT, load timer with LOCKOUT_CYC, clear the fail counter.
    - Otherwise: go to IDLE.
  - Buffer and count clear on exit in every case.
- OPEN: `unlocked`=1 and the timer decrements each cycle. Return to IDLE when the timer reaches expiry or on `lock_now`; `lock_now` wins over expiry. `digit_valid`, `enter` and `clear` are ignored.
- LOCKOUT: `locked_out`=1 and all inputs are ignored. Return to IDLE on timer expiry.
- Fail counter is 8 bits and saturating. It counts consecutive failures only.

## Timing
- All outputs are registered and have no combinational input-to-output path.
- `enter` sampled at edge N: CHECK during cycle N+1; outputs update at edge N+2.
- Pass: `unlocked` is high for exactly OPEN_CYC cycles starting at edge N+2.
- Fail: `fail_pulse` is high for exactly cycle N+2.
- Lockout: `locked_out` is high for exactly LOCKOUT_CYC cycles starting at edge N+2.
- `lock_now` sampled at edge M while OPEN: `unlocked` is 0 from edge M+1.
- `digit_count` updates the edge after `digit_valid`.
- `reset_n` low at any time, mid-entry or mid-timer: return immediately to reset values; the stored code reverts to `DEFAULT_CODE`.

## Configuration
- `LOCK_SEQUENCER_CODE_CHANGE_EN` defined:
  - The `set_code` port exists.
  - In OPEN, `set_code` moves to SETCODE: `unlocked` drops the next edge, the buffer and count clear, and the timer stops.
  - In SETCODE, digits are collected with the same rules as ENTRY.
  - `enter` with `digit_count`==DIGITS stores the buffer as the new code, then goes to IDLE.
  - `enter` with fewer digits, or `clear`, aborts: code unchanged, go to IDLE, no failure counted.
- Undefined: no `set_code` port, no SETCODE state; the code is the constant `DEFAULT_CODE`.

## Test plan
- Digits 1,A,2,B then `enter` -> `unlocked` high for 8 cycles starting 2 edges after `enter`; `fail_pulse` stays 0.
- Digits 1,A,2,C then `enter`, three times -> `fail_pulse` after each check; after the third, `locked_out` high for 16 cycles. Digits and `enter` sent during lockout have no effect.
- Fail twice, then enter the correct code, then fail twice -> no lockout, because the pass cleared the fail count.
- Digits 1,A then `clear` then 1,A,2,B `enter` -> open with no `fail_pulse`. Digits 1,A,2 then `enter` together with B -> open. Six digits starting 1,A,2,B -> count saturates at 4 and the code opens.
- Open, then `lock_now` at cycle 3 -> `unlocked` low the next edge. `reset_n` pulsed low mid-entry -> all outputs 0 and `digit_count` 0 immediately.
- With macro: open, `set_code`, digits 5,5,5,5, `enter` -> 1,A,2,B now fails and 5,5,5,5 opens. `set_code` then 5,5 `enter` -> old code retained.
